router_pkt_tx: RTL

//  Packet source for the 3-port router: drives router pkt_valid/data_in, honours router busy.

---
 rtl/router_pkt_tx_pkg.sv | 10 +
 rtl/router_pkt_tx_buf.sv | 28 ++
 rtl/router_pkt_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_pkg.sv
// router_pkt_tx_pkg: header field widths, illegal address code, FSM states and header packing
package router_pkt_tx_pkg;
    localparam int LEN_W = 6;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PAYLD, S_PAR, S_GAP} state_e;
    function automatic logic [7:0] mk_hdr(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction
endpackage

// File: rtl/router_pkt_tx_buf.sv
// router_pkt_tx_buf: payload register buffer with synchronous write and registered, write-bypassed read
module router_pkt_tx_buf
    import router_pkt_tx_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we_i,
    input  logic [LEN_W-1:0] wa_i,
    input  logic [7:0]       wd_i,
    input  logic             re_i,
    input  logic [LEN_W-1:0] ra_i,
    output logic [7:0]       rd_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;
    // storage writes; no reset so a packet's leftovers are simply overwritten by the next one
    always_ff @(posedge clock) begin
        if (we_i) mem_q[wa_i] <= wd_i;
    end
    // prefetch register; bypass covers a 1-byte packet whose only byte is written as it is read
    always_ff @(posedge clock) begin
        if (reset) rd_q <= '0;
        else if (re_i) rd_q <= (we_i && wa_i == ra_i) ? wd_i : mem_q[ra_i];
    end
    assign rd_o = rd_q;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a command's payload then sends header, payload and parity to the router
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int BUF_DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [7:0]        pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [7:0]        data_out,
    output logic              tx_done,
    output logic              cmd_err
);
    state_e state_q, state_d;
    logic [LEN_W-1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d, len_q, len_d, ra;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] par_q, par_d, data_q, data_d, rd_data, hdr;
    logic pv_q, pv_d, cmd_ready_q, pl_ready_q, tx_done_q, tx_done_d, cmd_err_q, cmd_err_d;
    logic we, re, consume;
    assign hdr = mk_hdr(len_q, addr_q);
    assign consume = !busy;
    router_pkt_tx_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clock(clock),
        .reset(reset),
        .we_i (we),
        .wa_i (wr_q),
        .wd_i (pl_data),
        .re_i (re),
        .ra_i (ra),
        .rd_o (rd_data)
    );
    // next state; outputs are computed one cycle ahead so they leave the block registered
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        par_d     = par_q;
        data_d    = data_q;
        pv_d      = pv_q;
        tx_done_d = 1'b0;
        cmd_err_d = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        ra        = rd_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d = cmd_addr;
                len_d  = cmd_len;
                if (cmd_addr == ADDR_ILLEGAL || cmd_len == '0) cmd_err_d = 1'b1;
                else begin
                    state_d = S_LOAD;
                    wr_d    = '0;
                end
            end
            S_LOAD: if (pl_valid && pl_ready_q) begin
                we   = 1'b1;
                wr_d = wr_q + 6'd1;
                if (wr_q == len_q - 6'd1) begin
                    state_d = S_HDR;
                    pv_d    = 1'b1;
                    data_d  = hdr;
                    par_d   = hdr;
                    re      = 1'b1;
                    ra      = '0;
                    rd_d    = 6'd1;
                end
            end
            S_HDR: if (consume) begin
                state_d = S_PAYLD;
                data_d  = rd_data;
                re      = 1'b1;
                rd_d    = rd_q + 6'd1;
                cnt_d   = len_q - 6'd1;
            end
            S_PAYLD: if (consume) begin
                par_d = par_q ^ data_q;
                if (cnt_q == '0) begin
                    state_d = S_PAR;
                    pv_d    = 1'b0;
                    data_d  = par_q ^ data_q;
                end else begin
                    data_d = rd_data;
                    re     = 1'b1;
                    rd_d   = rd_q + 6'd1;
                    cnt_d  = cnt_q - 6'd1;
                end
            end
            S_PAR: if (consume) begin
                state_d   = S_GAP;
                tx_done_d = 1'b1;
                data_d    = '0;
                cnt_d     = LEN_W'(GAP_CYCLES - 1);
            end
            S_GAP: begin
                state_d = (cnt_q == '0) ? S_IDLE : S_GAP;
                cnt_d   = cnt_q - 6'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state and registered outputs; reset aborts any packet in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            par_q       <= '0;
            data_q      <= '0;
            pv_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            par_q       <= par_d;
            data_q      <= data_d;
            pv_q        <= pv_d;
            cmd_ready_q <= state_d == S_IDLE;
            pl_ready_q  <= state_d == S_LOAD;
            tx_done_q   <= tx_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end
    assign cmd_ready = cmd_ready_q;
    assign pl_ready  = pl_ready_q;
    assign pkt_valid = pv_q;
    assign data_out  = data_q;
    assign tx_done   = tx_done_q;
    assign cmd_err   = cmd_err_q;
endmodule
